// File: rtl/disparity_stream_packer.sv
// Packs the SGBM raw pixel stream into a saturated, flagged AXI4-Stream-style output.
// Buffers samples in a first-word-fall-through FIFO and reports raster-order and overflow errors.
module disparity_stream_packer #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int DISP_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clkin,
    input  logic                          rst,
    input  logic [31:0]                   disparity,
    input  logic [9:0]                    row_in,
    input  logic [9:0]                    col_in,
    input  logic                          valid_in,
    output logic [DISP_W-1:0]             m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tuser,
    output logic                          m_tlast,
    output logic                          frame_done,
    output logic                          overflow,
    output logic                          sync_err,
    input  logic                          clear_err,
    output logic [15:0]                   drop_count,
    output logic [15:0]                   frame_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DISP_W + 3;
    localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
    localparam logic [9:0] ROW_LAST = 10'(IMG_H - 1);
    localparam logic [31:0] SAT_MAX = 32'((64'd1 << DISP_W) - 64'd1);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);

    // Entry layout: {eof, tlast, tuser, tdata}
    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       level;
    logic [9:0]        exp_row;
    logic [9:0]        exp_col;

    logic [DISP_W-1:0] sat_data;
    logic              in_tuser;
    logic              in_tlast;
    logic              in_eof;
    logic              in_range;
    logic              push_req;
    logic              pos_err;
    logic              range_err;
    logic              full;
    logic              pop;
    logic              push;
    logic              ovf_drop;
    logic              drop_ev;
    logic [9:0]        nxt_row;
    logic [9:0]        nxt_col;
    logic [EW-1:0]     rd_entry;

    always_comb begin
        sat_data = (disparity > SAT_MAX) ? '1 : disparity[DISP_W-1:0];
        in_tuser = (row_in == 10'd0) && (col_in == 10'd0);
        in_tlast = (col_in == COL_LAST);
        in_eof   = in_tlast && (row_in == ROW_LAST);
        in_range = (col_in <= COL_LAST) && (row_in <= ROW_LAST);
    end

    always_comb begin
        nxt_row = row_in;
        nxt_col = col_in + 10'd1;
        if (col_in == COL_LAST) begin
            nxt_col = 10'd0;
            nxt_row = (row_in == ROW_LAST) ? 10'd0 : row_in + 10'd1;
        end
    end

    always_comb begin
        rd_entry  = mem[rd_ptr];
        m_tvalid  = (level != '0);
        m_tdata   = m_tvalid ? rd_entry[DISP_W-1:0] : '0;
        m_tuser   = m_tvalid && rd_entry[DISP_W];
        m_tlast   = m_tvalid && rd_entry[DISP_W+1];
        full      = (level == LVL_FULL);
        pop       = m_tvalid && m_tready;
        push_req  = valid_in && in_range;
        range_err = valid_in && !in_range;
        pos_err   = push_req && ((row_in != exp_row) || (col_in != exp_col));
        // A full FIFO still accepts when the head leaves in the same cycle.
        push      = push_req && (!full || pop);
        ovf_drop  = push_req && full && !pop;
        drop_ev   = range_err || ovf_drop;
        fifo_level = level;
    end

    always_ff @(posedge clkin) begin
        if (!rst && push) begin
            mem[wr_ptr] <= {in_eof, in_tlast, in_tuser, sat_data};
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            exp_row     <= '0;
            exp_col     <= '0;
            overflow    <= 1'b0;
            sync_err    <= 1'b0;
            drop_count  <= '0;
            frame_count <= '0;
            frame_done  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase

            // Resync on every in-range sample, matching or not.
            if (push_req) begin
                exp_row <= nxt_row;
                exp_col <= nxt_col;
            end

            if (ovf_drop) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end

            if (pos_err || range_err) begin
                sync_err <= 1'b1;
            end else if (clear_err) begin
                sync_err <= 1'b0;
            end

            if (drop_ev && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end

            frame_done <= pop && rd_entry[DISP_W+2];
            if (pop && rd_entry[DISP_W+2]) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_disparity_stream_packer.sv
// Bench for disparity_stream_packer on a 4x2 frame with a 16-deep FIFO.
// A queue-based reference model tracks the expected beats, flags and counters.
module tb_disparity_stream_packer;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int DEPTH = 16;
    localparam int DW    = 8;

    logic          clkin = 1'b0;
    logic          rst;
    logic [31:0]   disparity;
    logic [9:0]    row_in;
    logic [9:0]    col_in;
    logic          valid_in;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tuser;
    logic          m_tlast;
    logic          frame_done;
    logic          overflow;
    logic          sync_err;
    logic          clear_err;
    logic [15:0]   drop_count;
    logic [15:0]   frame_count;
    logic [4:0]    fifo_level;

    disparity_stream_packer #(
        .IMG_W(W), .IMG_H(H), .DISP_W(DW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clkin(clkin), .rst(rst), .disparity(disparity), .row_in(row_in),
        .col_in(col_in), .valid_in(valid_in), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tuser(m_tuser), .m_tlast(m_tlast),
        .frame_done(frame_done), .overflow(overflow), .sync_err(sync_err),
        .clear_err(clear_err), .drop_count(drop_count), .frame_count(frame_count),
        .fifo_level(fifo_level)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        logic [DW-1:0] data;
        bit            tuser;
        bit            tlast;
        bit            eof;
    } beat_t;

    beat_t mq[$];
    int    m_er, m_ec, m_drops, m_frames;
    bit    m_ovf, m_serr, m_fd;

    bit            obs_valid, obs_user, obs_last, exp_valid;
    logic [DW-1:0] obs_data;
    beat_t         exp_beat;

    int checks   = 0;
    int failures = 0;

    task automatic do_reset();
        rst = 1'b1; valid_in = 1'b0; m_tready = 1'b0; clear_err = 1'b0;
        disparity = '0; row_in = '0; col_in = '0;
        @(posedge clkin);
        @(negedge clkin);
        rst = 1'b0;
        mq.delete();
        m_er = 0; m_ec = 0; m_drops = 0; m_frames = 0;
        m_ovf = 0; m_serr = 0; m_fd = 0;
    endtask

    // One clock: drive inputs, capture the head beat, advance the model, settle after the edge.
    task automatic step(input bit v, input int r, input int c, input logic [31:0] d,
                        input bit rdy, input bit clr);
        bit pop, in_rng, set_s, set_o, do_push;
        int idx;
        beat_t b, popped;
        valid_in = v; row_in = 10'(r); col_in = 10'(c); disparity = d;
        m_tready = rdy; clear_err = clr;
        #1;
        obs_valid = m_tvalid; obs_data = m_tdata; obs_user = m_tuser; obs_last = m_tlast;
        exp_valid = (mq.size() > 0);
        if (exp_valid) exp_beat = mq[0];
        pop = exp_valid && rdy;
        in_rng = (r < H) && (c < W);
        set_s = 0; set_o = 0; do_push = 0;
        b = '{default: '0};
        if (v && !in_rng) begin
            set_s = 1;
            if (m_drops < 65535) m_drops++;
        end
        if (v && in_rng) begin
            if (r != m_er || c != m_ec) set_s = 1;
            idx = (r * W + c + 1) % (W * H);
            m_er = idx / W;
            m_ec = idx % W;
            b.data  = (d > 32'd255) ? 8'hFF : d[7:0];
            b.tuser = (r == 0) && (c == 0);
            b.tlast = (c == W - 1);
            b.eof   = b.tlast && (r == H - 1);
            if (mq.size() < DEPTH || pop) begin
                do_push = 1;
            end else begin
                set_o = 1;
                if (m_drops < 65535) m_drops++;
            end
        end
        m_fd = 0;
        if (pop) begin
            popped = mq.pop_front();
            if (popped.eof) begin
                m_fd = 1;
                m_frames = (m_frames + 1) % 65536;
            end
        end
        if (do_push) mq.push_back(b);
        m_serr = set_s ? 1'b1 : (clr ? 1'b0 : m_serr);
        m_ovf  = set_o ? 1'b1 : (clr ? 1'b0 : m_ovf);
        @(posedge clkin);
        @(negedge clkin);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({m_tvalid, m_tdata, m_tuser, m_tlast, frame_done, overflow, sync_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got v=%0b d=%0d u=%0b l=%0b fd=%0b ov=%0b se=%0b want all 0",
                     m_tvalid, m_tdata, m_tuser, m_tlast, frame_done, overflow, sync_err);
        end
        checks++;
        if ({drop_count, frame_count, fifo_level} !== '0) begin
            failures++;
            $display("FAIL reset_counters got drops=%0d frames=%0d level=%0d want 0 0 0",
                     drop_count, frame_count, fifo_level);
        end
    endtask

    task automatic test_clean_frame();
        int n_beats = 0, n_user = 0, n_last = 0, n_fd = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) step(1, i / W, i % W, 32'(i), 1, 0);
            else       step(0, 0, 0, 32'd0, 1, 0);
            checks++;
            if (obs_valid !== exp_valid) begin
                failures++;
                $display("FAIL clean_valid cyc=%0d got=%0b want=%0b", i, obs_valid, exp_valid);
            end
            if (exp_valid && obs_valid) begin
                checks++;
                if ({obs_data, obs_user, obs_last} !== {exp_beat.data, exp_beat.tuser, exp_beat.tlast}) begin
                    failures++;
                    $display("FAIL clean_beat cyc=%0d got d=%0d u=%0b l=%0b want d=%0d u=%0b l=%0b", i,
                             obs_data, obs_user, obs_last, exp_beat.data, exp_beat.tuser, exp_beat.tlast);
                end
            end
            checks++;
            if (frame_done !== m_fd) begin
                failures++;
                $display("FAIL clean_frame_done cyc=%0d got=%0b want=%0b", i, frame_done, m_fd);
            end
            if (obs_valid) n_beats++;
            if (obs_valid && obs_user) n_user++;
            if (obs_valid && obs_last) n_last++;
            if (frame_done) n_fd++;
        end
        checks++;
        if (n_beats != 8 || n_user != 1 || n_last != 2 || n_fd != 1) begin
            failures++;
            $display("FAIL clean_totals got beats=%0d tuser=%0d tlast=%0d fd=%0d want 8 1 2 1",
                     n_beats, n_user, n_last, n_fd);
        end
        checks++;
        if (frame_count !== 16'd1 || overflow !== 1'b0 || sync_err !== 1'b0) begin
            failures++;
            $display("FAIL clean_status got frames=%0d ov=%0b se=%0b want 1 0 0",
                     frame_count, overflow, sync_err);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] vals[6];
        logic [31:0] d;
        vals[0] = 32'd255; vals[1] = 32'd256; vals[2] = 32'hFFFF_FFFF;
        vals[3] = 32'd17;  vals[4] = 32'd0;   vals[5] = 32'd254;
        for (int i = 0; i < 26; i++) begin
            d = (i < 6) ? vals[i] : ($urandom >> $urandom_range(0, 31));
            step(i < 22, m_er, m_ec, d, 1, 0);
            if (exp_valid) begin
                checks++;
                if (!obs_valid || obs_data !== exp_beat.data) begin
                    failures++;
                    $display("FAIL sat_data cyc=%0d got v=%0b d=%0d want d=%0d",
                             i, obs_valid, obs_data, exp_beat.data);
                end
            end
        end
        checks++;
        if (sync_err !== 1'b0 || fifo_level !== 5'd0) begin
            failures++;
            $display("FAIL sat_status got se=%0b level=%0d want 0 0", sync_err, fifo_level);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] seen[$];
        do_reset();
        for (int i = 0; i < 20; i++) step(1, m_er, m_ec, 32'(i + 1), 0, 0);
        checks++;
        if (fifo_level !== 5'd16 || overflow !== 1'b1 || drop_count !== 16'd4) begin
            failures++;
            $display("FAIL bp_fill got level=%0d ov=%0b drops=%0d want 16 1 4",
                     fifo_level, overflow, drop_count);
        end
        step(1, m_er, m_ec, 32'd100, 1, 0);
        if (obs_valid) seen.push_back(obs_data);
        checks++;
        if (fifo_level !== 5'd16 || drop_count !== 16'd4) begin
            failures++;
            $display("FAIL full_pop got level=%0d drops=%0d want 16 4", fifo_level, drop_count);
        end
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 32'd0, 1, 0);
            if (obs_valid) seen.push_back(obs_data);
        end
        checks++;
        if (seen.size() != 17) begin
            failures++;
            $display("FAIL bp_beat_count got=%0d want=17", seen.size());
        end
        for (int i = 0; i < 17 && i < seen.size(); i++) begin
            checks++;
            if (seen[i] !== ((i < 16) ? DW'(i + 1) : DW'(100))) begin
                failures++;
                $display("FAIL bp_order idx=%0d got=%0d want=%0d",
                         i, seen[i], (i < 16) ? i + 1 : 100);
            end
        end
    endtask

    task automatic test_order_range();
        do_reset();
        step(1, 0, 0, 32'd5, 0, 0);
        step(1, 0, 1, 32'd6, 0, 0);
        checks++;
        if (sync_err !== 1'b0) begin
            failures++; $display("FAIL order_clean got se=%0b want 0", sync_err);
        end
        step(1, 0, 3, 32'd7, 0, 0);
        checks++;
        if (sync_err !== 1'b1 || fifo_level !== 5'd3) begin
            failures++; $display("FAIL order_skip got se=%0b level=%0d want 1 3", sync_err, fifo_level);
        end
        step(0, 0, 0, 32'd0, 0, 1);
        checks++;
        if (sync_err !== 1'b0) begin
            failures++; $display("FAIL order_clear got se=%0b want 0", sync_err);
        end
        step(1, 1, 0, 32'd8, 0, 0);
        checks++;
        if (sync_err !== 1'b0 || fifo_level !== 5'd4) begin
            failures++; $display("FAIL order_resync got se=%0b level=%0d want 0 4", sync_err, fifo_level);
        end
        step(1, 0, 700, 32'd9, 0, 0);
        checks++;
        if (sync_err !== 1'b1 || drop_count !== 16'd1 || fifo_level !== 5'd4) begin
            failures++;
            $display("FAIL range_col got se=%0b drops=%0d level=%0d want 1 1 4",
                     sync_err, drop_count, fifo_level);
        end
        step(0, 0, 0, 32'd0, 0, 1);
        checks++;
        if (sync_err !== 1'b0 || drop_count !== 16'd1) begin
            failures++; $display("FAIL range_clear got se=%0b drops=%0d want 0 1", sync_err, drop_count);
        end
        step(1, H, 0, 32'd9, 0, 1);
        checks++;
        if (sync_err !== 1'b1 || drop_count !== 16'd2) begin
            failures++; $display("FAIL set_wins got se=%0b drops=%0d want 1 2", sync_err, drop_count);
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 32'd0, 1, 0);
            if (exp_valid) begin
                checks++;
                if (!obs_valid || obs_data !== exp_beat.data || obs_user !== exp_beat.tuser) begin
                    failures++;
                    $display("FAIL order_drain idx=%0d got v=%0b d=%0d u=%0b want d=%0d u=%0b", i,
                             obs_valid, obs_data, obs_user, exp_beat.data, exp_beat.tuser);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int r, c, sel;
            logic [31:0] d;
            bit v, rdy, clr;
            sel = $urandom_range(0, 31);
            r = m_er; c = m_ec;
            if (sel == 0) c = 700;
            else if (sel < 3) begin
                r = $urandom_range(0, H);
                c = $urandom_range(0, W);
            end
            d   = $urandom >> $urandom_range(0, 31);
            v   = ($urandom_range(0, 3) != 0);
            rdy = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            step(v, r, c, d, rdy, clr);
            checks++;
            if (obs_valid !== exp_valid ||
                (exp_valid && {obs_data, obs_user, obs_last} !==
                              {exp_beat.data, exp_beat.tuser, exp_beat.tlast})) begin
                failures++;
                $display("FAIL rnd_beat cyc=%0d got v=%0b d=%0d u=%0b l=%0b want v=%0b d=%0d u=%0b l=%0b",
                         i, obs_valid, obs_data, obs_user, obs_last, exp_valid,
                         exp_beat.data, exp_beat.tuser, exp_beat.tlast);
            end
            checks++;
            if (fifo_level !== 5'(mq.size()) || overflow !== m_ovf || sync_err !== m_serr) begin
                failures++;
                $display("FAIL rnd_status cyc=%0d got level=%0d ov=%0b se=%0b want %0d %0b %0b",
                         i, fifo_level, overflow, sync_err, mq.size(), m_ovf, m_serr);
            end
            checks++;
            if (drop_count !== 16'(m_drops) || frame_count !== 16'(m_frames) || frame_done !== m_fd) begin
                failures++;
                $display("FAIL rnd_counts cyc=%0d got drops=%0d frames=%0d fd=%0b want %0d %0d %0b",
                         i, drop_count, frame_count, frame_done, m_drops, m_frames, m_fd);
            end
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 3; i++) step(1, 0, i, 32'(i + 40), 0, 0);
        checks++;
        if (fifo_level == 5'd0) begin
            failures++; $display("FAIL midframe_prefill got level=%0d want nonzero", fifo_level);
        end
        do_reset();
        checks++;
        if (m_tvalid !== 1'b0 || fifo_level !== 5'd0) begin
            failures++; $display("FAIL midframe_abort got v=%0b level=%0d want 0 0", m_tvalid, fifo_level);
        end
        checks++;
        if ({drop_count, frame_count, overflow, sync_err} !== '0) begin
            failures++;
            $display("FAIL midframe_counters got drops=%0d frames=%0d ov=%0b se=%0b want 0",
                     drop_count, frame_count, overflow, sync_err);
        end
        test_clean_frame();
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; m_tready = 1'b0; clear_err = 1'b0;
        disparity = '0; row_in = '0; col_in = '0;
        @(negedge clkin);
        test_reset();
        test_clean_frame();
        test_saturation();
        test_backpressure();
        test_order_range();
        test_random();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
